// File: rtl/dac_frame_sequencer_if.sv
// Bus between the command/value generator and the DAC frame sequencer.
// Handshake: start is a request level, taken only when the sequencer is not
// busy (IDLE or the DONE cycle); the sequencer answers with busy for the whole
// transaction and a single-cycle done pulse, and drives the three SPI pins.
interface dac_frame_sequencer_if;
    logic        start;
    logic [15:0] command;
    logic [15:0] value;
    logic        busy;
    logic        done;
    logic        sclk;
    logic        mosi;
    logic        cs_n;

    modport master (
        output start, command, value,
        input  busy, done, sclk, mosi, cs_n
    );

    modport slave (
        input  start, command, value,
        output busy, done, sclk, mosi, cs_n
    );
endinterface

// File: rtl/dac_frame_sequencer.sv
// Sends a latched command word, then a latched value word, as two SPI frames
// (MSB first, sclk idle low) separated by a cs_n-high gap. The pin outputs are
// decoded from the registered state, so they change one edge after a decision.
module dac_frame_sequencer #(
    parameter int CLK_DIV = 4,
    parameter int GAP     = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    dac_frame_sequencer_if.slave   bus,
    output logic [2:0]             state_dbg
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_SHIFT_HI = 3'd2,
        ST_SHIFT_LO = 3'd3,
        ST_GAP      = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    localparam logic [15:0] DIV_RELOAD = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_RELOAD = 16'(GAP - 1);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] cmd_q;
    logic [15:0] val_q;
    logic        frame;      // 0: command frame, 1: value frame
    logic [4:0]  bit_cnt;    // bits already clocked out of the current frame
    logic [15:0] div_cnt;    // cycles left in the current phase, minus one

    logic        accept;
    logic        phase_end;
    logic [15:0] cur_word;
    logic [3:0]  bit_idx;
    logic        cur_bit;

    assign accept    = bus.start && (state == ST_IDLE || state == ST_DONE);
    assign phase_end = (div_cnt == 16'd0);
    assign cur_word  = frame ? val_q : cmd_q;
    // After the last bit the index stays on bit 0 so mosi holds through the hold time.
    assign bit_idx   = bit_cnt[4] ? 4'd0 : (4'd15 - bit_cnt[3:0]);
    assign cur_bit   = cur_word[bit_idx];
    assign state_dbg = state;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decision and Moore decode of the pins and status.
    always_comb begin
        state_nxt = state;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        bus.sclk  = 1'b0;
        bus.mosi  = 1'b0;
        bus.cs_n  = 1'b1;
        case (state)
            ST_IDLE: begin
                if (bus.start) state_nxt = ST_SETUP;
            end
            ST_SETUP: begin
                bus.busy = 1'b1;
                bus.cs_n = 1'b0;
                bus.mosi = cur_bit;
                if (phase_end) state_nxt = ST_SHIFT_HI;
            end
            ST_SHIFT_HI: begin
                bus.busy = 1'b1;
                bus.cs_n = 1'b0;
                bus.sclk = 1'b1;
                bus.mosi = cur_bit;
                if (phase_end) state_nxt = ST_SHIFT_LO;
            end
            ST_SHIFT_LO: begin
                bus.busy = 1'b1;
                bus.cs_n = 1'b0;
                bus.mosi = cur_bit;
                if (phase_end) begin
                    if (bit_cnt == 5'd16) begin
                        state_nxt = frame ? ST_DONE : ST_GAP;
                    end else begin
                        state_nxt = ST_SHIFT_HI;
                    end
                end
            end
            ST_GAP: begin
                bus.busy = 1'b1;
                if (phase_end) state_nxt = ST_SETUP;
            end
            ST_DONE: begin
                bus.done  = 1'b1;
                state_nxt = bus.start ? ST_SETUP : ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Word latches, frame select, bit counter and phase divider.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_q   <= 16'd0;
            val_q   <= 16'd0;
            frame   <= 1'b0;
            bit_cnt <= 5'd0;
            div_cnt <= 16'd0;
        end else if (accept) begin
            cmd_q   <= bus.command;
            val_q   <= bus.value;
            frame   <= 1'b0;
            bit_cnt <= 5'd0;
            div_cnt <= DIV_RELOAD;
        end else begin
            case (state)
                ST_SETUP, ST_SHIFT_HI, ST_SHIFT_LO: begin
                    if (phase_end) begin
                        div_cnt <= DIV_RELOAD;
                        if (state == ST_SHIFT_HI) begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                        if (state == ST_SHIFT_LO && bit_cnt == 5'd16 && !frame) begin
                            div_cnt <= GAP_RELOAD;
                        end
                    end else begin
                        div_cnt <= div_cnt - 16'd1;
                    end
                end
                ST_GAP: begin
                    if (phase_end) begin
                        frame   <= 1'b1;
                        bit_cnt <= 5'd0;
                        div_cnt <= DIV_RELOAD;
                    end else begin
                        div_cnt <= div_cnt - 16'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dac_frame_sequencer.sv
// Bench for dac_frame_sequencer: two instances (default rate and fastest rate)
// checked cycle by cycle against a waveform model computed from the frame timing.
module tb_dac_frame_sequencer;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    dac_frame_sequencer_if if0 ();
    dac_frame_sequencer_if if1 ();
    logic [2:0] dbg0;
    logic [2:0] dbg1;

    dac_frame_sequencer #(.CLK_DIV(4), .GAP(2)) dut0 (
        .clk       (clk),
        .reset     (reset),
        .bus       (if0),
        .state_dbg (dbg0)
    );

    dac_frame_sequencer #(.CLK_DIV(1), .GAP(1)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .bus       (if1),
        .state_dbg (dbg1)
    );

    // ---------------- scoreboard counters ----------------
    int vec_cnt;
    int miss_cnt;

    // ---------------- vector table ----------------
    typedef struct {
        int          which;
        int          d;
        int          g;
        logic [15:0] cmd;
        logic [15:0] val;
        int          mode;           // 0 plain, 1 inputs change, 2 stray starts, 3 start held
        logic [31:0] exp_bits;       // last 32 bits captured on sclk rising edges
        int          exp_edges;
        int          exp_done_cycle; // first done pulse
        int          exp_done_count;
    } vec_t;

    vec_t vecs[5];

    // Expected {busy, done, sclk, mosi, cs_n} for cycle t after start is taken at edge 0.
    function automatic logic [4:0] model(int d, int g, logic [15:0] c, logic [15:0] v, int t);
        int f;
        int u;
        int k;
        logic [15:0] w;
        logic s;
        logic m;
        f = 33 * d;
        u = 0;
        w = 16'd0;
        if (t >= 1 && t <= f) begin
            w = c;
            u = t - 1;
        end else if (t > f && t <= f + g) begin
            return 5'b10001;
        end else if (t > f + g && t <= 2 * f + g) begin
            w = v;
            u = t - f - g - 1;
        end else if (t == 2 * f + g + 1) begin
            return 5'b01001;
        end else begin
            return 5'b00001;
        end
        if (u < d) begin
            s = 1'b0;
            m = w[15];
        end else begin
            k = (u - d) / (2 * d);
            s = ((u - d) % (2 * d)) < d;
            if (s) m = w[15 - k];
            else   m = (k < 15) ? w[14 - k] : w[0];
        end
        return {1'b1, 1'b0, s, m, 1'b0};
    endfunction

    function automatic logic [4:0] outs(int which);
        if (which == 0) return {if0.busy, if0.done, if0.sclk, if0.mosi, if0.cs_n};
        return {if1.busy, if1.done, if1.sclk, if1.mosi, if1.cs_n};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(int which, logic st, logic [15:0] c, logic [15:0] v);
        if (which == 0) begin
            if0.start = st; if0.command = c; if0.value = v;
        end else begin
            if1.start = st; if1.command = c; if1.value = v;
        end
    endtask

    task automatic set_start(int which, logic st);
        if (which == 0) if0.start = st;
        else            if1.start = st;
    endtask

    task automatic check_out(string name, int t, logic [4:0] act, logic [4:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s cycle=%0d actual{busy,done,sclk,mosi,cs_n}=%b required=%b",
                     name, t, act, exp);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Runs one transaction from a negedge, comparing every cycle to the model.
    task automatic run_txn(vec_t tv);
        int n;
        int last;
        int t;
        int edges;
        int done_first;
        int done_count;
        logic prev_sclk;
        logic [31:0] cap;
        logic [4:0] o;
        logic [4:0] e;
        n = 66 * tv.d + tv.g + 1;
        last = (tv.mode == 3) ? 2 * n + 10 : n + 10;
        edges = 0;
        done_first = -1;
        done_count = 0;
        prev_sclk = 1'b0;
        cap = 32'd0;
        drive(tv.which, 1'b1, tv.cmd, tv.val);
        @(posedge clk);
        for (t = 1; t <= last; t++) begin
            @(negedge clk);
            o = outs(tv.which);
            e = (tv.mode == 3 && t > n) ? model(tv.d, tv.g, tv.cmd, tv.val, t - n)
                                        : model(tv.d, tv.g, tv.cmd, tv.val, t);
            check_out("wave", t, o, e);
            if (o[2] && !prev_sclk) begin
                edges++;
                cap = {cap[30:0], o[1]};
            end
            prev_sclk = o[2];
            if (o[3]) begin
                done_count++;
                if (done_first < 0) done_first = t;
            end
            if (t == 1 && tv.mode != 3) set_start(tv.which, 1'b0);
            if (tv.mode == 1 && t == 10) drive(tv.which, 1'b0, 16'hFFFF, 16'h0ABC);
            if (tv.mode == 2 && (t == 50 || t == 200)) set_start(tv.which, 1'b1);
            if (tv.mode == 2 && (t == 51 || t == 201)) set_start(tv.which, 1'b0);
            if (tv.mode == 3 && t == n + 1) set_start(tv.which, 1'b0);
        end
        check_int("captured_bits", int'(cap), int'(tv.exp_bits));
        check_int("rising_edges", edges, tv.exp_edges);
        check_int("done_cycle", done_first, tv.exp_done_cycle);
        check_int("done_count", done_count, tv.exp_done_count);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vec_t rv;
        logic [15:0] rc;
        logic [15:0] rvl;
        vec_cnt  = 0;
        miss_cnt = 0;
        reset = 1'b1;
        drive(0, 1'b0, 16'd0, 16'd0);
        drive(1, 1'b0, 16'd0, 16'd0);

        vecs[0] = '{0, 4, 2, 16'h0C00, 16'h0123, 0, 32'h0C000123, 32, 267, 1};
        vecs[1] = '{0, 4, 2, 16'h0C00, 16'h0123, 1, 32'h0C000123, 32, 267, 1};
        vecs[2] = '{0, 4, 2, 16'h0C00, 16'h0123, 2, 32'h0C000123, 32, 267, 1};
        vecs[3] = '{0, 4, 2, 16'h0C00, 16'h0123, 3, 32'h0C000123, 64, 267, 2};
        vecs[4] = '{1, 1, 1, 16'hFFFF, 16'h0000, 0, 32'hFFFF0000, 32, 68, 1};

        // Reset held three cycles with random inputs on both instances.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            drive(0, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
            drive(1, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
            @(negedge clk);
            check_out("reset0", i, outs(0), 5'b00001);
            check_out("reset1", i, outs(1), 5'b00001);
        end
        drive(0, 1'b0, 16'd0, 16'd0);
        drive(1, 1'b0, 16'd0, 16'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Directed table.
        for (int i = 0; i < 5; i++) begin
            run_txn(vecs[i]);
        end

        // Randomized words on both rates.
        for (int i = 0; i < 6; i++) begin
            rc  = 16'($urandom);
            rvl = 16'($urandom);
            rv = '{i % 2, (i % 2) ? 1 : 4, (i % 2) ? 1 : 2, rc, rvl, 0,
                   {rc, rvl}, 32, (i % 2) ? 68 : 267, 1};
            run_txn(rv);
        end

        // Reset during bit 5 of the value frame, then a fresh transaction.
        rc  = 16'($urandom);
        rvl = 16'($urandom);
        drive(0, 1'b1, rc, rvl);
        @(posedge clk);
        for (int t = 1; t <= 180; t++) begin
            @(negedge clk);
            check_out("pre_reset", t, outs(0), model(4, 2, rc, rvl, t));
            if (t == 1) set_start(0, 1'b0);
        end
        reset = 1'b1;
        @(negedge clk);
        check_out("mid_reset", 181, outs(0), 5'b00001);
        reset = 1'b0;
        for (int t = 182; t < 482; t++) begin
            @(negedge clk);
            check_out("post_reset_idle", t, outs(0), 5'b00001);
        end
        run_txn(vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/dac_frame_sequencer.md
# dac_frame_sequencer

Sequences one command word and one value word out to the serial DAC link as two back-to-back SPI frames. The block sits between the value/command generator and the DAC pins. It latches both 16-bit words on a start strobe and drives sclk/mosi/cs_n with a programmable bit rate. It reports busy and a one-cycle done pulse so the upstream logic can schedule the next update.

## Interface
- CLK_DIV, default 4: clk cycles per sclk half-period; legal range 1..65535.
- GAP, default 2: clk cycles cs_n is held high between the command frame and the value frame; legal range 1..255.

- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset, sampled on rising edge of clk.
- start  in  1  request a transaction; sampled only when busy=0.
- command  in  16  command word, sent first, MSB first.
- value  in  16  value word, sent second, MSB first.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the transaction completes.
- sclk  out  1  serial clock, idle low.
- mosi  out  1  serial data, changes only while sclk is low.
- cs_n  out  1  active-low chip select, one low period per frame.

## Operation
- Reset values of all outputs: busy=0, done=0, sclk=0, mosi=0, cs_n=1. Reset also returns the FSM to IDLE and clears the latched words.
- FSM states: IDLE, SETUP, SHIFT_HI, SHIFT_LO, GAP, DONE.
- IDLE: if start=1, latch command and value into internal registers and select frame 0 (command). Go to SETUP.
- Later changes on the command/value inputs have no effect until the next accepted start.
- SETUP: cs_n=0, sclk=0, mosi=current word[15]. Lasts CLK_DIV cycles, then go to SHIFT_HI.
- SHIFT_HI: sclk=1 for CLK_DIV cycles. The DAC samples mosi on the sclk rising edge. Then go to SHIFT_LO.
- SHIFT_LO: sclk=0 for CLK_DIV cycles. On entry mosi advances to the next lower bit.
  - After bit 0, mosi holds bit 0.
  - If 16 bits have been sent, go to GAP when on frame 0, or to DONE when on frame 1. Otherwise go back to SHIFT_HI.
  - The low phase after bit 0 serves as the cs_n hold time.
- GAP: cs_n=1, sclk=0, mosi=0 for GAP cycles. Then select frame 1 (value) and go to SETUP.
- DONE: cs_n=1, sclk=0, mosi=0, done=1, busy=0 for exactly one cycle, then go to IDLE.
  - start is also accepted in DONE; the next transaction then begins as from IDLE.
- start while busy=1 is ignored and not queued.
- Reset mid-transaction: outputs return to their reset values on the next clock edge. The frame is abandoned and done is not pulsed.
- Bit counter is 5 bits (0..16). Divider counter is 16 bits and reloads at each phase boundary.

## Timing
- Let D=CLK_DIV and G=GAP, with start sampled high at edge 0.
- Cycles 1..33D: cs_n=0 for the command frame. Made up of D setup cycles, then 16×(D high + D low) cycles.
- Cycles 33D+1..33D+G: cs_n=1 (gap).
- Cycles 33D+G+1..66D+G: cs_n=0 for the value frame.
- Cycle 66D+G+1: done=1, busy=0, cs_n=1.
- Defaults (D=4, G=2): cs_n low 1..132 and 135..266; done at cycle 267.
- busy=1 during cycles 1..66D+G.
- Rising sclk edge k (k=0..15) in a frame occurs D+2kD cycles after that frame's cs_n fall. mosi is stable for D cycles before each rising edge and throughout the high phase.
- sclk period is 2D clk cycles; sclk never toggles while cs_n=1.

## Test plan
- Reset: hold reset 3 cycles with random inputs -> busy=0, done=0, sclk=0, mosi=0, cs_n=1. No sclk edges occur.
- Nominal transaction (D=4, G=2): command=0x0C00, value=0x0123 -> the bench captures 0x0C00 then 0x0123 on sclk rising edges. cs_n is low over 1..132 and 135..266, there are exactly 32 rising edges, and done is a single pulse at cycle 267.
- Input stability: after start, change command to 0xFFFF and value to 0x0ABC at cycle 10 -> the link still carries 0x0C00 and 0x0123.
- Handshake:
  - start pulsed at cycles 50 and 200 -> ignored, and exactly one transaction occurs.
  - start held high through the done cycle -> the second transaction's cs_n falls at cycle 268 with no idle gap.
- Reset mid-operation: assert reset during bit 5 of the value frame -> on the next cycle cs_n=1, sclk=0, busy=0, and no done pulse follows. A fresh start afterwards produces a full correct transaction.
- Boundary rate (D=1, G=1): command=0xFFFF, value=0x0000 -> each frame has cs_n low for 33 cycles with a 1-cycle gap, done at cycle 68, sclk period 2 cycles, and the captured bits are all ones then all zeros.
